// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial parity receiver and its transmitter peer.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    localparam logic       START_BIT   = 1'b0;
    localparam logic       STOP_BIT    = 1'b1;
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // 2-input XOR gate cell; parity trees are composed only from this.
    function automatic logic xor2(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/parity_tree.sv
// Balanced XOR reduction of W bits built from the xor2 cell; shared by the
// receiver and the transmitter.
module parity_tree #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_bits,
    output logic         o_par
);
    import serial_rx_pkg::*;

    localparam int NODES = 2 * W - 1;

    logic [NODES-1:0] w_node;

    // Heap-ordered tree: leaves occupy the top W slots, node k combines 2k+1 and 2k+2.
    always_comb begin
        w_node = {NODES{1'b0}};
        for (int i = 0; i < W; i++) begin
            w_node[W - 1 + i] = i_bits[i];
        end
        for (int k = W - 2; k >= 0; k--) begin
            w_node[k] = xor2(w_node[2 * k + 1], w_node[2 * k + 2]);
        end
        o_par = w_node[0];
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start + DATA_W data bits (LSB first) + parity + stop,
// delivered over valid/ready. Define RX_ERR_CNT_EN to add the err_cnt output.
module serial_parity_rx
    import serial_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit ODD_PAR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_en,
    input  logic              serial_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_par;
    logic              w_par_nxt;
    logic              w_done;
    logic              w_par_calc;
    logic              w_perr;
    logic              w_ferr;
    logic              w_load;

    parity_tree #(
        .W (DATA_W + 1)
    ) u_parity_tree (
        .i_bits ({r_shift, r_par}),
        .o_par  (w_par_calc)
    );

    assign w_perr = w_par_calc ^ ODD_PAR;
    assign w_ferr = (serial_in != STOP_BIT);
    // A completed frame is taken unless a held word is still waiting to be accepted.
    assign w_load = w_done & (~rx_valid | rx_ready);

    // Frame sequencer state, bit counter and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_shift <= {DATA_W{1'b0}};
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
        end
    end

    // Next-state logic; everything holds on cycles without a bit strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done      = 1'b0;
        if (bit_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (serial_in == START_BIT) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    w_shift_nxt = {serial_in, r_shift[DATA_W-1:1]};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    w_par_nxt   = serial_in;
                    w_state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Output word, status flags and the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= {DATA_W{1'b0}};
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data    <= r_shift;
                rx_valid   <= 1'b1;
                parity_err <= w_perr;
                frame_err  <= w_ferr;
            end else if (w_done) begin
                overrun    <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
            end
        end
    end

`ifdef RX_ERR_CNT_EN
    // Saturating count of delivered frames carrying an error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if (w_load && (w_perr || w_ferr) && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: directed scenarios plus randomized
// frames against a frame-level reference model.
module tb_serial_parity_rx;

    localparam int DATA_W  = 8;
    localparam bit ODD_PAR = 1'b0;

    logic              clk = 1'b0;
    logic              reset;
    logic              bit_en;
    logic              serial_in;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;
`ifdef RX_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: what the consumer should currently see.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_perr;
    logic              m_ferr;
    logic              m_ovr;
    int                m_errs;

    // Driver-side knowledge of the frame being sent.
    logic              tb_done;
    logic [DATA_W-1:0] tb_data;
    logic              tb_perr;
    logic              tb_ferr;
    int                rdy_mode;
    int                period;

    always #5 clk = ~clk;

    serial_parity_rx #(
        .DATA_W  (DATA_W),
        .ODD_PAR (ODD_PAR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_errs  = 0;
    endtask

    function automatic logic ready_value(input logic done);
        case (rdy_mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return logic'($urandom_range(0, 1));
            3:       return done;
            default: return 1'b1;
        endcase
    endfunction

    task automatic compare_all();
        chk_eq("rx_valid", rx_valid, m_valid);
        chk_eq("overrun", overrun, m_ovr);
        if (m_valid) begin
            chk_eq("rx_data", rx_data, m_data);
            chk_eq("parity_err", parity_err, m_perr);
            chk_eq("frame_err", frame_err, m_ferr);
        end
`ifdef RX_ERR_CNT_EN
        chk_eq("err_cnt", err_cnt, 32'(m_errs));
`endif
    endtask

    // One clock: advance the model with the inputs seen at this edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else if (tb_done) begin
            if (!m_valid || rx_ready) begin
                m_valid = 1'b1;
                m_data  = tb_data;
                m_perr  = tb_perr;
                m_ferr  = tb_ferr;
                if ((tb_perr || tb_ferr) && m_errs < 255) m_errs++;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rx_ready) begin
            m_valid = 1'b0;
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            serial_in = 1'b1;
            bit_en    = logic'($urandom_range(0, 1));
            tb_done   = 1'b0;
            rx_ready  = ready_value(1'b0);
            tick();
        end
    endtask

    // Sends the first nslots bit slots of a frame, each lasting 'period' clocks.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stop,
                              input int nslots);
        logic [DATA_W+2:0] bits;
        bits    = {stop, par, d, 1'b0};
        tb_data = d;
        tb_perr = (($countones({d, par}) % 2) != int'(ODD_PAR));
        tb_ferr = !stop;
        for (int s = 0; s < nslots; s++) begin
            for (int k = 0; k < period; k++) begin
                serial_in = bits[s];
                bit_en    = (k == period - 1);
                tb_done   = (s == DATA_W + 2) && (k == period - 1);
                rx_ready  = ready_value(tb_done);
                tick();
            end
        end
        bit_en    = 1'b0;
        serial_in = 1'b1;
        tb_done   = 1'b0;
    endtask

    function automatic logic good_par(input logic [DATA_W-1:0] d);
        return logic'(($countones(d) % 2) != int'(ODD_PAR));
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_eq("rst_rx_data", rx_data, 32'h0);
        chk_eq("rst_rx_valid", rx_valid, 32'h0);
        chk_eq("rst_parity_err", parity_err, 32'h0);
        chk_eq("rst_frame_err", frame_err, 32'h0);
        chk_eq("rst_overrun", overrun, 32'h0);
        model_clear();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        rx_ready  = 1'b0;
        tb_done   = 1'b0;
        tb_data   = '0;
        tb_perr   = 1'b0;
        tb_ferr   = 1'b0;
        period    = 1;
        rdy_mode  = 0;
        model_clear();
        do_reset();
        idle(2);

        // 1: clean frame, single-cycle valid pulse
        send_frame(8'hA5, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t1_valid", rx_valid, 32'h1);
        chk_eq("t1_data", rx_data, 32'hA5);
        chk_eq("t1_perr", parity_err, 32'h0);
        chk_eq("t1_ferr", frame_err, 32'h0);
        idle(1);
        chk_eq("t1_pulse", rx_valid, 32'h0);

        // 2: parity fault
        send_frame(8'h01, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t2_data", rx_data, 32'h01);
        chk_eq("t2_perr", parity_err, 32'h1);
`ifdef RX_ERR_CNT_EN
        chk_eq("t2_errcnt", err_cnt, 32'h1);
`endif
        idle(2);

        // 3: framing fault
        send_frame(8'h3C, 1'b0, 1'b0, DATA_W + 3);
        chk_eq("t3_ferr", frame_err, 32'h1);
        chk_eq("t3_perr", parity_err, 32'h0);
        idle(2);

        // 4: back-pressure and overrun
        rdy_mode = 1;
        send_frame(8'h11, 1'b0, 1'b1, DATA_W + 3);
        idle(2);
        send_frame(8'h22, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t4_hold", rx_data, 32'h11);
        chk_eq("t4_valid", rx_valid, 32'h1);
        chk_eq("t4_ovr", overrun, 32'h1);
        rdy_mode = 0;
        idle(1);
        chk_eq("t4_accept", rx_valid, 32'h0);

        // 5: sparse strobe, mid-frame reset, recovery
        period = 4;
        send_frame(8'h5A, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t5_data", rx_data, 32'h5A);
        chk_eq("t5_valid", rx_valid, 32'h1);
        idle(1);
        send_frame(8'hC3, 1'b0, 1'b1, 5);
        do_reset();
        idle(3);
        send_frame(8'hC3, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t5_rec_data", rx_data, 32'hC3);
        chk_eq("t5_rec_perr", parity_err, 32'h0);
        chk_eq("t5_rec_ferr", frame_err, 32'h0);
        idle(1);

        // 6: accept coincides with completion of the next frame
        period   = 1;
        rdy_mode = 3;
        send_frame(8'h96, 1'b0, 1'b1, DATA_W + 3);
        idle(3);
        chk_eq("t6_held", rx_data, 32'h96);
        send_frame(8'h69, 1'b0, 1'b1, DATA_W + 3);
        chk_eq("t6_data", rx_data, 32'h69);
        chk_eq("t6_valid", rx_valid, 32'h1);
        chk_eq("t6_ovr", overrun, 32'h0);
        rdy_mode = 0;
        idle(2);

        // Randomized frames, strobe spacing, errors and consumer stalls.
        rdy_mode = 2;
        for (int f = 0; f < 150; f++) begin
            logic [DATA_W-1:0] d;
            logic              par;
            logic              stop;
            d      = DATA_W'($urandom);
            par    = good_par(d) ^ logic'(($urandom % 5) == 0);
            stop   = logic'(($urandom % 6) != 0);
            period = $urandom_range(1, 4);
            send_frame(d, par, stop, DATA_W + 3);
            idle($urandom_range(0, 3));
        end

`ifdef RX_ERR_CNT_EN
        // Error counter saturation.
        rdy_mode = 0;
        period   = 1;
        for (int f = 0; f < 260; f++) begin
            send_frame(8'h01, 1'b0, 1'b1, DATA_W + 3);
        end
        chk_eq("errcnt_sat", err_cnt, 32'hFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
